// File: rtl/l2_mem_ctrl.sv
// l2_mem_ctrl: block-granular backing memory that sits behind L2_cache.
// It serves whole-block reads (miss fills) and whole-block writes
// (write-through / write-back). Each has its own fixed latency, and every
// completion is signalled with a one-cycle mem_ready pulse.
//
// Ports
//   clk, rst        rising-edge clock, synchronous active-high reset
//   mem_addr        word address; only the block index bits are used
//   mem_read        block read request (level, held until mem_ready)
//   mem_write       block write request (level, held until mem_ready)
//   mem_data_in     write block, word i at [i*DATA_WIDTH +: DATA_WIDTH]
//   mem_data_block  last read block, same packing
//   mem_ready       one-cycle completion pulse
//   mem_busy        high whenever the controller is not idle
//   err_collision   pulse: read and write were both high at accept
//   rd_count        completed reads (saturating)
//   wr_count        completed writes (saturating)
module l2_mem_ctrl #(
  parameter int DATA_WIDTH    = 32,
  parameter int ADDR_WIDTH    = 11,
  parameter int BLOCK_SIZE    = 32,
  parameter int READ_LATENCY  = 4,
  parameter int WRITE_LATENCY = 2
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [ADDR_WIDTH-1:0]            mem_addr,
  input  logic                             mem_read,
  input  logic                             mem_write,
  input  logic [BLOCK_SIZE*DATA_WIDTH-1:0] mem_data_in,
  output logic [BLOCK_SIZE*DATA_WIDTH-1:0] mem_data_block,
  output logic                             mem_ready,
  output logic                             mem_busy,
  output logic                             err_collision,
  output logic [15:0]                      rd_count,
  output logic [15:0]                      wr_count
);

  localparam int OFF_BITS   = $clog2(BLOCK_SIZE);
  localparam int IDX_W      = ADDR_WIDTH - OFF_BITS;
  localparam int NUM_BLOCKS = 1 << IDX_W;
  localparam int BLK_W      = BLOCK_SIZE * DATA_WIDTH;
  localparam int MAX_LAT    = (READ_LATENCY > WRITE_LATENCY) ? READ_LATENCY : WRITE_LATENCY;
  localparam int CNT_W      = $clog2(MAX_LAT) + 1;

  localparam logic [CNT_W-1:0] RD_CNT0 = CNT_W'(READ_LATENCY - 1);
  localparam logic [CNT_W-1:0] WR_CNT0 = CNT_W'(WRITE_LATENCY - 1);

  typedef enum logic [1:0] {IDLE, RD_WAIT, WR_WAIT, DONE} state_t;

  // Request captured at accept; later input changes must not leak in.
  typedef struct packed {
    logic [IDX_W-1:0] idx;
    logic [BLK_W-1:0] data;
  } req_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  req_t             req;
  logic             accept;
  logic             wr_fire;

  // Storage is deliberately outside reset; it powers up as zeros.
  logic [BLK_W-1:0] mem_q [NUM_BLOCKS] = '{default: '0};

  // Offset bits select a word inside the block, which this block never needs.
  logic unused_off;
  assign unused_off = ^mem_addr[OFF_BITS-1:0];

  assign accept  = (state == IDLE) && (mem_read || mem_write);
  assign wr_fire = (state == WR_WAIT) && (cnt == '0);

  always_ff @(posedge clk) begin
    if (!rst && accept) begin
      req.idx  <= mem_addr[ADDR_WIDTH-1:OFF_BITS];
      req.data <= mem_data_in;
    end
  end

  // Reset gates the commit, so an in-flight write aborted by rst leaves the
  // array untouched.
  always_ff @(posedge clk) begin
    if (!rst && wr_fire) mem_q[req.idx] <= req.data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= IDLE;
      cnt            <= '0;
      mem_ready      <= 1'b0;
      mem_busy       <= 1'b0;
      err_collision  <= 1'b0;
      mem_data_block <= '0;
      rd_count       <= '0;
      wr_count       <= '0;
    end else begin
      mem_ready     <= 1'b0;
      err_collision <= 1'b0;
      case (state)
        IDLE: begin
          // Write wins a collision; the read is dropped, not queued.
          if (mem_write) begin
            state         <= WR_WAIT;
            cnt           <= WR_CNT0;
            mem_busy      <= 1'b1;
            err_collision <= mem_read;
          end else if (mem_read) begin
            state    <= RD_WAIT;
            cnt      <= RD_CNT0;
            mem_busy <= 1'b1;
          end
        end
        RD_WAIT: begin
          if (cnt == '0) begin
            mem_data_block <= mem_q[req.idx];
            mem_ready      <= 1'b1;
            state          <= DONE;
            rd_count       <= rd_count + {15'd0, rd_count != 16'hFFFF};
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        WR_WAIT: begin
          if (cnt == '0) begin
            mem_ready <= 1'b1;
            state     <= DONE;
            wr_count  <= wr_count + {15'd0, wr_count != 16'hFFFF};
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        DONE: begin
          // One ready cycle, then back to IDLE. A request still held there
          // is accepted as a new one.
          state    <= IDLE;
          mem_busy <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_l2_mem_ctrl.sv
module tb_l2_mem_ctrl;
  localparam int DW = 32, AW = 11, BS = 32, RL = 4, WL = 2;
  localparam int BW = BS * DW, OFF = 5, NB = 64;

  logic          clk = 1'b0;
  logic          rst;
  logic [AW-1:0] mem_addr;
  logic          mem_read, mem_write;
  logic [BW-1:0] mem_data_in, mem_data_block;
  logic          mem_ready, mem_busy, err_collision;
  logic [15:0]   rd_count, wr_count;

  always #5 clk = ~clk;

  l2_mem_ctrl #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .BLOCK_SIZE(BS),
    .READ_LATENCY(RL), .WRITE_LATENCY(WL)
  ) dut (
    .clk(clk), .rst(rst), .mem_addr(mem_addr), .mem_read(mem_read),
    .mem_write(mem_write), .mem_data_in(mem_data_in),
    .mem_data_block(mem_data_block), .mem_ready(mem_ready),
    .mem_busy(mem_busy), .err_collision(err_collision),
    .rd_count(rd_count), .wr_count(wr_count)
  );

  typedef struct {
    logic          is_rd;
    logic [BW-1:0] data;
    int            lat;
    logic          err;
  } exp_t;

  typedef struct {
    string         name;
    logic          rd, wr;
    logic [AW-1:0] addr;
    logic [31:0]   seed;
    logic          inc;
  } vec_t;

  exp_t          sb[$];
  logic [BW-1:0] model [NB];
  logic [BW-1:0] last_rd;
  int            exp_rd, exp_wr;
  int            checks = 0, errors = 0;

  // Reports the first differing 32-bit word so FAIL lines stay short.
  task automatic chk(input string name, input logic [BW-1:0] act, input logic [BW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      for (int w = 0; w < BS; w++)
        if (act[w*DW +: DW] !== exp[w*DW +: DW]) begin
          $display("FAIL %s word%0d act=%h exp=%h", name, w, act[w*DW +: DW], exp[w*DW +: DW]);
          break;
        end
    end
  endtask

  function automatic logic [BW-1:0] pat(input logic [31:0] seed, input logic inc);
    logic [BW-1:0] b;
    for (int i = 0; i < BS; i++) b[i*DW +: DW] = inc ? (seed ^ 32'(i)) : seed;
    return b;
  endfunction

  // Drive a request and push what the DUT must return for it.
  task automatic issue(input logic rd, input logic wr, input logic [AW-1:0] addr, input logic [BW-1:0] data);
    exp_t e;
    int   idx;
    idx   = int'(addr[AW-1:OFF]);
    e.err = rd && wr;
    if (wr) begin
      e.is_rd = 1'b0; e.lat = WL; e.data = '0;
      model[idx] = data;
    end else begin
      e.is_rd = 1'b1; e.lat = RL; e.data = model[idx];
    end
    sb.push_back(e);
    mem_addr = addr; mem_read = rd; mem_write = wr; mem_data_in = data;
  endtask

  // Called at the negedge of the ready cycle.
  task automatic retire(input string name, input int lat, input logic errs);
    exp_t e;
    checks++;
    if (sb.size() == 0) begin
      errors++;
      $display("FAIL %s.sb act=empty exp=entry", name);
      return;
    end
    e = sb.pop_front();
    chk({name, ".ready"}, BW'(mem_ready), BW'(1));
    chk({name, ".lat"}, BW'(lat), BW'(e.lat));
    chk({name, ".err"}, BW'(errs), BW'(e.err));
    chk({name, ".busy"}, BW'(mem_busy), BW'(1));
    if (e.is_rd) begin
      exp_rd++;
      last_rd = e.data;
    end else begin
      exp_wr++;
    end
    chk({name, ".data"}, mem_data_block, last_rd);
    chk({name, ".rd_cnt"}, BW'(rd_count), BW'(exp_rd));
    chk({name, ".wr_cnt"}, BW'(wr_count), BW'(exp_wr));
  endtask

  task automatic idle_chk(input string name);
    @(posedge clk); @(negedge clk);
    chk({name, ".ready_drop"}, BW'(mem_ready), BW'(0));
    chk({name, ".idle"}, BW'(mem_busy), BW'(0));
  endtask

  // Full transaction: starts and ends on a negedge.
  task automatic run_txn(input string name, input logic rd, input logic wr,
                         input logic [AW-1:0] addr, input logic [BW-1:0] data);
    int   lat;
    logic errs, busy_ok;
    issue(rd, wr, addr, data);
    @(posedge clk); @(negedge clk);
    errs    = err_collision;
    busy_ok = mem_busy;
    lat     = 0;
    while (!mem_ready && lat < 40) begin
      @(posedge clk); lat++; @(negedge clk);
      busy_ok &= mem_busy;
    end
    mem_read = 1'b0; mem_write = 1'b0;
    chk({name, ".busy_span"}, BW'(busy_ok), BW'(1));
    retire(name, lat, errs);
    idle_chk(name);
  endtask

  vec_t vt[8];

  initial begin
    #400000;
    $display("FAIL watchdog act=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vt[0] = '{"rd_unwritten", 1'b1, 1'b0, 11'h00A, 32'h0,        1'b0};
    vt[1] = '{"wr_blk0",      1'b0, 1'b1, 11'h014, 32'hA5A5A5A5, 1'b1};
    vt[2] = '{"rd_blk0",      1'b1, 1'b0, 11'h01F, 32'hDEADBEEF, 1'b1};
    vt[3] = '{"wr_blk63",     1'b0, 1'b1, 11'h7E0, 32'h5A5A5A5A, 1'b1};
    vt[4] = '{"rd_blk63",     1'b1, 1'b0, 11'h7FF, 32'h0,        1'b0};
    vt[5] = '{"rd_blk0_keep", 1'b1, 1'b0, 11'h000, 32'h0,        1'b0};
    vt[6] = '{"collision",    1'b1, 1'b1, 11'h040, 32'h12345678, 1'b0};
    vt[7] = '{"rd_coll",      1'b1, 1'b0, 11'h040, 32'h0,        1'b0};

    for (int b = 0; b < NB; b++) model[b] = '0;
    last_rd = '0; exp_rd = 0; exp_wr = 0;
    mem_addr = '0; mem_read = 1'b0; mem_write = 1'b0; mem_data_in = '0;

    // Reset state
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst.ready", BW'(mem_ready), BW'(0));
    chk("rst.busy", BW'(mem_busy), BW'(0));
    chk("rst.err", BW'(err_collision), BW'(0));
    chk("rst.data", mem_data_block, '0);
    chk("rst.rd_cnt", BW'(rd_count), BW'(0));
    chk("rst.wr_cnt", BW'(wr_count), BW'(0));
    rst = 1'b0;

    for (int i = 0; i < 8; i++) begin
      run_txn(vt[i].name, vt[i].rd, vt[i].wr, vt[i].addr, pat(vt[i].seed, vt[i].inc));
      if (i == 2) begin
        chk("rd_blk0.word0", BW'(mem_data_block[31:0]), BW'(32'hA5A5A5A5));
        chk("rd_blk0.word31", BW'(mem_data_block[BW-1 -: 32]), BW'(32'hA5A5A5BA));
      end
    end

    // Reset in the first WAIT cycle of a write aborts it.
    begin
      logic ready_seen;
      mem_addr = 11'h080; mem_write = 1'b1; mem_data_in = '1;
      @(posedge clk); @(negedge clk);
      rst = 1'b1; mem_write = 1'b0;
      @(posedge clk); @(negedge clk);
      rst = 1'b0;
      chk("rstmid.busy", BW'(mem_busy), BW'(0));
      chk("rstmid.rd_cnt", BW'(rd_count), BW'(0));
      chk("rstmid.wr_cnt", BW'(wr_count), BW'(0));
      chk("rstmid.data", mem_data_block, '0);
      ready_seen = mem_ready;
      repeat (4) begin
        @(posedge clk); @(negedge clk);
        ready_seen |= mem_ready;
      end
      chk("rstmid.no_ready", BW'(ready_seen), BW'(0));
      exp_rd = 0; exp_wr = 0; last_rd = '0;
      run_txn("rstmid_rd", 1'b1, 1'b0, 11'h080, '0);
    end

    // Input changes during RD_WAIT are ignored; a request held through DONE
    // is re-accepted in the following IDLE cycle.
    begin
      int   lat, gap;
      issue(1'b1, 1'b0, 11'h014, '0);
      @(posedge clk); @(negedge clk);
      lat = 0;
      mem_addr = 11'h7E0; mem_read = 1'b0;
      @(posedge clk); lat++; @(negedge clk);
      mem_read = 1'b1;
      while (!mem_ready && lat < 40) begin
        @(posedge clk); lat++; @(negedge clk);
      end
      retire("ign_first", lat, 1'b0);
      issue(1'b1, 1'b0, 11'h7E0, '0);
      gap = 0;
      @(posedge clk); gap++; @(negedge clk);
      while (!mem_ready && gap < 40) begin
        @(posedge clk); gap++; @(negedge clk);
      end
      mem_read = 1'b0;
      // One edge leaving DONE, one edge re-accepting, then the read latency.
      chk("ign.reaccept_gap", BW'(gap), BW'(RL + 2));
      retire("ign_second", gap - 2, 1'b0);
      idle_chk("ign_second");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/l2_mem_ctrl.md
Name: l2_mem_ctrl

Overview:
Block-granular backing-memory controller that sits directly downstream of L2_cache on its memory-side interface. It serves whole-block reads (L2 miss fills) and whole-block writes (L2 write-through and write-back) with fixed, parameterised latencies, signalling completion with a one-cycle mem_ready pulse. It is the synthesizable and simulation memory model used for L2 integration benches.

Parameters:
DATA_WIDTH, 32, bits per word
ADDR_WIDTH, 11, word address width; matches L2_cache
BLOCK_SIZE, 32, words per block (power of 2)
READ_LATENCY, 4, cycles from read accept to mem_ready (>=1)
WRITE_LATENCY, 2, cycles from write accept to mem_ready (>=1)
Derived: OFF_BITS = log2(BLOCK_SIZE); NUM_BLOCKS = 2^(ADDR_WIDTH-OFF_BITS), which is 64 with the defaults.

Ports:
clk  in  1  single clock, rising edge
rst  in  1  synchronous reset, active-high
mem_addr  in  ADDR_WIDTH  word address from L2; block index = mem_addr[ADDR_WIDTH-1:OFF_BITS]; offset bits ignored
mem_read  in  1  block read request, level, held by L2 until mem_ready
mem_write  in  1  block write request, level, held by L2 until mem_ready
mem_data_in  in  BLOCK_SIZE*DATA_WIDTH  write block from L2 (L2's mem_data_out); word i at [i*DATA_WIDTH +: DATA_WIDTH]
mem_data_block  out  BLOCK_SIZE*DATA_WIDTH  read block to L2, same packing
mem_ready  out  1  one-cycle completion pulse for read or write
mem_busy  out  1  high whenever state != IDLE
err_collision  out  1  one-cycle pulse: read and write both high when a request is accepted
rd_count  out  16  completed reads, saturating at 16'hFFFF
wr_count  out  16  completed writes, saturating at 16'hFFFF

Behaviour:
- Storage: NUM_BLOCKS x (BLOCK_SIZE*DATA_WIDTH) array. Contents are not cleared by rst. Contents are zero at time 0 in simulation.
- FSM states and transitions:
  - IDLE -> RD_WAIT or WR_WAIT on request acceptance.
  - RD_WAIT / WR_WAIT -> DONE when the latency counter reaches 0.
  - DONE -> IDLE unconditionally.
- Accept rule: a request is accepted on a rising edge in IDLE when mem_read or mem_write is high.
  - Block index and mem_data_in are latched at acceptance. Later changes to the inputs have no effect.
  - cnt is loaded with LATENCY-1.
- Priority: if mem_read and mem_write are both high at acceptance, the write is taken, the read is dropped, and err_collision pulses in the cycle after acceptance.
- Latency: with acceptance at edge T0, each edge in a WAIT state at which cnt != 0 decrements cnt. At the edge where cnt == 0:
  - Read: mem_data_block <= array[idx] and mem_ready <= 1.
  - Write: array[idx] <= latched data and mem_ready <= 1.
  - State moves to DONE.
  - mem_ready is therefore high exactly in the cycle after edge T0+LATENCY. READ_LATENCY=4 gives ready in the 5th cycle after the accept cycle.
- DONE: mem_ready=1 and mem_busy=1. Requests are ignored. Next edge clears mem_ready and returns to IDLE. A request still high in IDLE is treated as a new request, so the requester must drop its request upon seeing mem_ready.
- Requests are never queued. Requests arriving in WAIT or DONE are ignored.
- mem_data_block holds the last read result until the next read completes. Writes do not change it, even to the same block.
- Read-after-write: a read accepted after a write's DONE cycle returns the written data.
- Counters: rd_count / wr_count increment at the completion edge and saturate at 16'hFFFF.
- Reset (rst high at an edge, including mid-operation):
  - state=IDLE, cnt=0.
  - mem_ready=0, mem_busy=0, err_collision=0.
  - mem_data_block=0, rd_count=0, wr_count=0.
  - An in-flight write is aborted and the array is not modified.
  - rst has priority over all other events.

Test Plan:
1. Read of unwritten block: rst for 2 cycles; mem_addr=11'h00A, mem_read held -> mem_ready pulses exactly one cycle, 5 cycles after the accept cycle; mem_data_block all zeros; rd_count=1; mem_busy high from the cycle after accept through the ready cycle.
2. Write then read: write addr 11'h014 with word i = 32'hA5A5A5A5^i -> ready 3 cycles after accept, wr_count=1. Then read 11'h01F (same block 0) -> word 0 = 32'hA5A5A5A5, word 31 = 32'hA5A5A5BA.
3. Offset aliasing and overwrite: write block at 11'h7E0 with 32'h5A5A5A5A^i, then read 11'h7FF -> same block returned. Read 11'h000 -> block-0 data unaffected.
4. Collision: mem_read and mem_write both high in IDLE at addr 11'h040, data 32'h12345678 -> err_collision pulse one cycle after accept; write latency used; wr_count increments, rd_count unchanged; a subsequent read of 11'h040 returns 32'h12345678 in all words.
5. Reset mid-write: accept write of 32'hFFFFFFFF to 11'h080, assert rst in the first WAIT cycle -> no mem_ready, counters 0, mem_busy 0; a subsequent read of 11'h080 returns the prior contents (zeros).
6. Ignored requests: toggle mem_addr/mem_read during RD_WAIT -> the original address is served; holding mem_read through DONE causes a second accept in the IDLE cycle after DONE (rd_count=2).
